// File: rtl/seq_detect_fsm.sv
// Mealy serial-pattern detector with KMP fallback and a saturating match counter.
// Define SEQ_DETECT_REG_OUT_EN to register y so it pulses one cycle after the match.
module seq_detect_fsm #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter int                   CNT_W     = 8,
    parameter int                   ST_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_valid,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             y,
    output logic [ST_W-1:0]  s,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int SDEPTH = 1 << ST_W;

    // Bit i of the pattern in arrival order (i = 0 is received first).
    function automatic logic pat_bit(input int i);
        logic [PATTERN_W-1:0] t;
        t = PATTERN >> (PATTERN_W - 1 - i);
        return t[0];
    endfunction

    // Longest pattern prefix (shorter than the pattern) that ends the
    // history "first k pattern bits followed by b".
    function automatic int fallback(input int k, input logic b);
        int   best;
        logic ok;
        logic c;
        best = 0;
        for (int j = 1; j <= k + 1; j++) begin
            if (j < PATTERN_W) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    c = (k + 1 - j + i == k) ? b : pat_bit(k + 1 - j + i);
                    if (c != pat_bit(i)) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    function automatic int border();
        int   best;
        logic ok;
        best = 0;
        for (int j = 1; j < PATTERN_W; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (pat_bit(PATTERN_W - j + i) != pat_bit(i)) ok = 1'b0;
            end
            if (ok) best = j;
        end
        return best;
    endfunction

    localparam logic [ST_W-1:0] LAST_S   = ST_W'(PATTERN_W - 1);
    localparam logic [ST_W-1:0] BORDER_S = ST_W'(border());

    // Table spans every encodable state; unreachable codes fall back to 0.
    logic [ST_W-1:0] nxt0 [SDEPTH];
    logic [ST_W-1:0] nxt1 [SDEPTH];

    for (genvar k = 0; k < SDEPTH; k++) begin : g_tbl
        localparam int N0 = (k < PATTERN_W) ? fallback(k, 1'b0) : 0;
        localparam int N1 = (k < PATTERN_W) ? fallback(k, 1'b1) : 0;
        assign nxt0[k] = ST_W'(N0);
        assign nxt1[k] = ST_W'(N1);
    end

    logic            match;
    logic [ST_W-1:0] s_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '0;
        end else begin
            s <= s_nxt;
        end
    end

    always_comb begin
        match = 1'b0;
        s_nxt = s;
        if (!rst && x_valid && (s == LAST_S) && (x == PATTERN[0])) begin
            match = 1'b1;
        end
        if (match) begin
            s_nxt = overlap ? BORDER_S : '0;
        end else if (x_valid) begin
            s_nxt = x ? nxt1[s] : nxt0[s];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            match_cnt <= '0;
        end else if (match && !cnt_sat) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end

    assign cnt_sat = &match_cnt;

`ifdef SEQ_DETECT_REG_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            y <= 1'b0;
        end else begin
            y <= match;
        end
    end
`else
    assign y = match;
`endif

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Scoreboard bench for seq_detect_fsm (PATTERN 1011, CNT_W=2): stimulus pushes
// hand-computed expectations, a monitor pops and compares once per cycle.
module tb_seq_detect_fsm;

    localparam int ST_W  = 4;
    localparam int CNT_W = 2;
`ifdef SEQ_DETECT_REG_OUT_EN
    localparam bit REG_Y = 1'b1;
`else
    localparam bit REG_Y = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             x = 1'b0;
    logic             x_valid = 1'b0;
    logic             overlap = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             y;
    logic [ST_W-1:0]  s;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    seq_detect_fsm #(
        .PATTERN_W(4),
        .PATTERN  (4'b1011),
        .CNT_W    (CNT_W),
        .ST_W     (ST_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .x_valid  (x_valid),
        .overlap  (overlap),
        .cnt_clr  (cnt_clr),
        .y        (y),
        .s        (s),
        .match_cnt(match_cnt),
        .cnt_sat  (cnt_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              chk;
        int              row;
        logic            ey;
        logic [ST_W-1:0] es;
        logic [CNT_W-1:0] ec;
        logic            esat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   row   = 0;
    logic prev_y = 1'b0;

    // es/ec/esat: registered values visible during the row (before its edge).
    // ey: combinational match for the row; shifted by one row when y is registered.
    task automatic step(input logic r, input logic xv, input logic xb, input logic ov,
                        input logic clr, input bit chk, input logic ey, input int es,
                        input int ec, input logic esat);
        exp_t e;
        @(negedge clk);
        rst = r; x_valid = xv; x = xb; overlap = ov; cnt_clr = clr;
        e.chk  = chk;
        e.row  = row;
        e.ey   = REG_Y ? prev_y : ey;
        e.es   = ST_W'(es);
        e.ec   = CNT_W'(ec);
        e.esat = esat;
        prev_y = ey;
        row++;
        sb.push_back(e);
    endtask

    task automatic go(input logic xv, input logic xb, input logic ov, input logic clr,
                      input logic ey, input int es, input int ec, input logic esat);
        step(1'b0, xv, xb, ov, clr, 1'b1, ey, es, ec, esat);
    endtask

    task automatic cmp(input string name, input int r, input int got, input int exp_v,
                       input bit known);
        tests++;
        if (!known || got != exp_v) begin
            fails++;
            $display("FAIL %s row %0d: got %0d (known=%0d) expected %0d", name, r, got, known, exp_v);
        end
    endtask

    // Monitor: samples between input update and the next active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    cmp("y",         e.row, int'(y),         int'(e.ey),   !$isunknown(y));
                    cmp("s",         e.row, int'(s),         int'(e.es),   !$isunknown(s));
                    cmp("match_cnt", e.row, int'(match_cnt), int'(e.ec),   !$isunknown(match_cnt));
                    cmp("cnt_sat",   e.row, int'(cnt_sat),   int'(e.esat), !$isunknown(cnt_sat));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with random inputs; state before the first edge is don't-care.
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);

        // Overlap: 1,0,1,1,0,1,1
        go(1, 1, 1, 0, 0, 0, 0, 0);
        go(1, 0, 1, 0, 0, 1, 0, 0);
        go(1, 1, 1, 0, 0, 2, 0, 0);
        go(1, 1, 1, 0, 1, 3, 0, 0);
        go(1, 0, 1, 0, 0, 1, 1, 0);
        go(1, 1, 1, 0, 0, 2, 1, 0);
        go(1, 1, 1, 0, 1, 3, 1, 0);
        go(0, 0, 1, 0, 0, 1, 2, 0);
        go(0, 0, 1, 1, 0, 1, 2, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0);

        // Non-overlap; overlap toggles before the match and must not matter
        go(1, 1, 1, 0, 0, 0, 0, 0);
        go(1, 0, 1, 0, 0, 1, 0, 0);
        go(1, 1, 1, 0, 0, 2, 0, 0);
        go(1, 1, 0, 0, 1, 3, 0, 0);
        go(1, 0, 0, 0, 0, 0, 1, 0);
        go(1, 1, 0, 0, 0, 0, 1, 0);
        go(1, 1, 0, 0, 0, 1, 1, 0);
        go(0, 0, 0, 0, 0, 1, 1, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 1'b0);

        // KMP fallback 1,1,0 then 3-cycle stall, then 1,1
        go(1, 1, 1, 0, 0, 0, 0, 0);
        go(1, 1, 1, 0, 0, 1, 0, 0);
        go(1, 0, 1, 0, 0, 1, 0, 0);
        go(0, 1, 1, 0, 0, 2, 0, 0);
        go(0, 1, 1, 0, 0, 2, 0, 0);
        go(0, 1, 1, 0, 0, 2, 0, 0);
        go(1, 1, 1, 0, 0, 2, 0, 0);
        go(1, 1, 1, 0, 1, 3, 0, 0);

        // Saturation: count 1 -> 2 -> 3 -> 3, then clear colliding with a match
        go(1, 0, 1, 0, 0, 1, 1, 0);
        go(1, 1, 1, 0, 0, 2, 1, 0);
        go(1, 1, 1, 0, 1, 3, 1, 0);
        go(1, 0, 1, 0, 0, 1, 2, 0);
        go(1, 1, 1, 0, 0, 2, 2, 0);
        go(1, 1, 1, 0, 1, 3, 2, 0);
        go(1, 0, 1, 0, 0, 1, 3, 1);
        go(1, 1, 1, 0, 0, 2, 3, 1);
        go(1, 1, 1, 0, 1, 3, 3, 1);
        go(1, 0, 1, 0, 0, 1, 3, 1);
        go(1, 1, 1, 0, 0, 2, 3, 1);
        go(1, 1, 1, 1, 1, 3, 3, 1);
        go(0, 0, 1, 0, 0, 1, 0, 0);

        // Reset while s=3 and the completing bit is present
        go(1, 0, 1, 0, 0, 1, 0, 0);
        go(1, 1, 1, 0, 0, 2, 0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3, 0, 1'b0);
        go(0, 0, 1, 0, 0, 0, 0, 0);
        go(0, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_detect_fsm.md
Name: seq_detect_fsm

Overview:
- Parametrised Mealy serial-pattern detector with synchronous reset, for the lab FSM family.
- Accepts one serial bit per qualified cycle and flags completion of a programmable PATTERN_W-bit pattern.
- Supports overlapping and non-overlapping match modes.
- Exposes the current state and a saturating match counter for the board display.

Parameters:
- PATTERN_W, 4, pattern length in bits; legal range 2..16
- PATTERN, 4'b1011, pattern to detect; bit PATTERN_W-1 is received first, bit 0 last
- CNT_W, 8, width of match counter
- ST_W, 4, width of state output; must satisfy 2**ST_W >= PATTERN_W

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- x  input  1  serial data bit
- x_valid  input  1  x qualifier; bit consumed only when high
- overlap  input  1  1 = overlapping matches, 0 = non-overlapping
- cnt_clr  input  1  synchronous clear of match_cnt
- y  output  1  match pulse (Mealy)
- s  output  ST_W  current state = number of pattern bits matched so far
- match_cnt  output  CNT_W  saturating count of matches
- cnt_sat  output  1  high while match_cnt is at its maximum (2**CNT_W-1)

Behaviour:
- Reset: rst sampled high at a posedge (synchronous only, no async path) forces s=0, match_cnt=0, cnt_sat=0 and any registered y to 0. Reset overrides all other inputs, including in-progress partial matches.
- State meaning: s = largest k < PATTERN_W such that the last k consumed bits equal PATTERN[PATTERN_W-1 -: k]. "Consumed bits" are cleared by a non-overlap match.
- Next state is computed combinationally and registered each posedge; s holds when x_valid=0.
- Mismatch follows KMP fallback (longest pattern prefix that is a suffix of history + x), not a blind return to 0. The transition table is derived from PATTERN at elaboration; there is no per-pattern hand coding.
- Match condition: x_valid=1, s=PATTERN_W-1 and x=PATTERN[0].
- y (no option): combinational, y = match condition, same cycle as the final bit, zero latency. y=0 whenever x_valid=0.
- Next state on match:
  - overlap=1: longest proper prefix-suffix (border) of PATTERN. For 1011 this is 1.
  - overlap=0: 0.
- overlap is sampled only on the match cycle. Changing it mid-sequence affects no partial state.
- match_cnt:
  - Increments by 1 on each match.
  - Saturates at 2**CNT_W-1; cnt_sat=1 while at max.
  - cnt_clr=1 sets it to 0 next cycle and takes priority over a same-cycle match (that match is not counted).
  - cnt_clr does not affect s or y.
- Any s value not reachable from the derived table (corruption) returns to 0 on the next valid bit.
- No outputs are X after the first reset; before reset, s is don't-care.

Optional Feature:
- Macro: SEQ_DETECT_REG_OUT_EN.
- Defined: y is registered (a Moore-style output). It pulses exactly one cycle after the match cycle and resets to 0. match_cnt timing is unchanged (it updates on the same edge as the y register).
- Undefined: y is combinational, as specified in Behaviour.

Test Plan:
- Reset check: rst=1 for 2 cycles with random x/x_valid -> s=0, match_cnt=0, cnt_sat=0, y=0; rst released -> first valid bit is processed normally.
- Overlap mode: overlap=1, x_valid=1, x sequence 1,0,1,1,0,1,1 -> s = 1,2,3,match,2,3,match. y high on bits 4 and 7; match_cnt=2; s=1 after each match.
- Non-overlap mode: overlap=0, same sequence -> y high on bit 4 only; s after bit 4 = 0; s after bits 5..7 = 0,1,1; match_cnt=1.
- KMP fallback and stall: sequence 1,1,0,1,1 with x_valid=0 inserted for 3 cycles after bit 3 -> s holds at 2 during the stall, y=0 during the stall, y high on bit 5.
- Counter saturation and clear: CNT_W=2, 4 matches -> match_cnt = 1,2,3,3 with cnt_sat=1 from the third match. Then cnt_clr asserted in the same cycle as a match -> match_cnt=0 next cycle while y still pulses.
- Reset mid-operation and macro: s=3 then rst=1 with x=1 -> no y pulse counted, s=0. With SEQ_DETECT_REG_OUT_EN defined, rerun the overlap test -> y pulses shifted one cycle later, match_cnt values unchanged.
